// File: rtl/rf_wb_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// Source ids double as the write-data mux select encoding.
package rf_wb_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef logic src_t;
  localparam src_t SRC_ALU = 1'b0;
  localparam src_t SRC_LD  = 1'b1;

  typedef struct packed {
    logic            full;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] data;
  } slot_t;

endpackage

// File: rtl/rf_wb_if.sv
// Producer-side handshakes and register-file write port of the write-back arbiter.
// The master side is the environment (producers + register file); the slave side is the arbiter.
interface rf_wb_if #(
  parameter int XLEN = rf_wb_pkg::XLEN,
  parameter int RA_W = rf_wb_pkg::RA_W
);

  logic            alu_valid;
  logic [RA_W-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            ld_valid;
  logic [RA_W-1:0] ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic            wd_sel;
  logic [XLEN-1:0] wd_data0;
  logic [XLEN-1:0] wd_data1;
  logic            wb_busy;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, rf_we, rf_waddr, wd_sel, wd_data0, wd_data1, wb_busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, rf_we, rf_waddr, wd_sel, wd_data0, wd_data1, wb_busy
  );

endinterface

// File: rtl/wb_slot.sv
// One-entry write-back buffer for a single producer.
// Requests to x0 are accepted but never stored; a refill on the draining edge wins.
module wb_slot
  import rf_wb_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic [RA_W-1:0] rd,
  input  logic [XLEN-1:0] data,
  input  logic            grant,
  output logic            ready,
  output logic            fill,
  output slot_t           slot
);

  // Ready looks only at registered state so it never combinationally follows valid.
  assign ready = !slot.full || grant;
  assign fill  = valid && ready && (rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (fill) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      slot <= '{full: 1'b1, rd: rd, data: data};
    end else if (grant) begin
      slot.full <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-source write-back arbiter: oldest-first grant, round-robin on a same-edge tie,
// registered write enable, address, mux select and mux data inputs.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int XLEN = rf_wb_pkg::XLEN,
  parameter int RA_W = rf_wb_pkg::RA_W
) (
  input logic    clk,
  input logic    rst_n,
  rf_wb_if.slave bus
);

  slot_t alu_slot, ld_slot;
  logic  alu_fill, ld_fill;
  logic  alu_grant, ld_grant;
  logic  ld_older, age_tie;
  src_t  last_grant, tie_winner;

  logic            rf_we_q, wd_sel_q;
  logic [RA_W-1:0] rf_waddr_q;
  logic [XLEN-1:0] wd_data0_q, wd_data1_q;

  wb_slot u_alu_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (bus.alu_valid),
    .rd    (bus.alu_rd),
    .data  (bus.alu_data),
    .grant (alu_grant),
    .ready (bus.alu_ready),
    .fill  (alu_fill),
    .slot  (alu_slot)
  );

  wb_slot u_ld_slot (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (bus.ld_valid),
    .rd    (bus.ld_rd),
    .data  (bus.ld_data),
    .grant (ld_grant),
    .ready (bus.ld_ready),
    .fill  (ld_fill),
    .slot  (ld_slot)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    alu_grant  = 1'b0;
    ld_grant   = 1'b0;
    tie_winner = ~last_grant;
    if (alu_slot.full && ld_slot.full) begin
      ld_grant  = age_tie ? (tie_winner == SRC_LD) : ld_older;
      alu_grant = !ld_grant;
    end else begin
      alu_grant = alu_slot.full;
      ld_grant  = ld_slot.full;
    end
  end

  // Age is only meaningful while both slots are full; it is refreshed on every fill
  // that lands next to an entry that stays behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_older <= 1'b0;
      age_tie  <= 1'b0;
    end else if (alu_fill && ld_fill) begin
      age_tie <= 1'b1;
    end else if (alu_fill && ld_slot.full && !ld_grant) begin
      age_tie  <= 1'b0;
      ld_older <= 1'b1;
    end else if (ld_fill && alu_slot.full && !alu_grant) begin
      age_tie  <= 1'b0;
      ld_older <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset too, so the mux inputs are defined right after reset.
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      wd_sel_q   <= SRC_ALU;
      wd_data0_q <= '0;
      wd_data1_q <= '0;
      last_grant <= SRC_LD;
    end else if (alu_grant || ld_grant) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= ld_grant ? ld_slot.rd : alu_slot.rd;
      wd_sel_q   <= ld_grant ? SRC_LD : SRC_ALU;
      last_grant <= ld_grant ? SRC_LD : SRC_ALU;
      if (ld_grant) wd_data1_q <= ld_slot.data;
      else          wd_data0_q <= alu_slot.data;
    end else begin
      rf_we_q <= 1'b0;
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.wd_sel   = wd_sel_q;
  assign bus.wd_data0 = wd_data0_q;
  assign bus.wd_data1 = wd_data1_q;
  assign bus.wb_busy  = alu_slot.full || ld_slot.full || rf_we_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a per-cycle vector table plus hand-written
// sequences for tie-after-reset, sustained contention and reset mid-operation.
module tb_rf_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  rf_wb_if #(.XLEN(32), .RA_W(5)) bus ();

  rf_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Inputs are applied for the coming edge; expectations describe the cycle they are applied in.
  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        we;
    logic [4:0]  wa;
    logic        sel;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        ar;
    logic        lr;
    logic        busy;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ld;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rf_we"},     64'(bus.rf_we),     64'd0);
    check({tag, "_rf_waddr"},  64'(bus.rf_waddr),  64'd0);
    check({tag, "_wd_sel"},    64'(bus.wd_sel),    64'd0);
    check({tag, "_wd_data0"},  64'(bus.wd_data0),  64'd0);
    check({tag, "_wd_data1"},  64'(bus.wd_data1),  64'd0);
    check({tag, "_alu_ready"}, 64'(bus.alu_ready), 64'd1);
    check({tag, "_ld_ready"},  64'(bus.ld_ready),  64'd1);
    check({tag, "_wb_busy"},   64'(bus.wb_busy),   64'd0);
  endtask

  initial begin
    logic prev_ar, prev_lr;
    logic exp_we, exp_sel;

    // ALU-only write, tie won by load (last grant was ALU), x0 discard, then age order on rd 7.
    vecs[0]  = '{1, 3,  32'hDEADBEEF, 0, 0,  0,     0, 0,  0, 0,            0,     1, 1, 0};
    vecs[1]  = '{0, 0,  0,            0, 0,  0,     0, 0,  0, 0,            0,     1, 1, 1};
    vecs[2]  = '{0, 0,  0,            0, 0,  0,     1, 3,  0, 32'hDEADBEEF, 0,     1, 1, 1};
    vecs[3]  = '{1, 5,  32'h11,       1, 6,  32'h22, 0, 3, 0, 32'hDEADBEEF, 0,     1, 1, 0};
    vecs[4]  = '{0, 0,  0,            0, 0,  0,     0, 3,  0, 32'hDEADBEEF, 0,     0, 1, 1};
    vecs[5]  = '{0, 0,  0,            0, 0,  0,     1, 6,  1, 32'hDEADBEEF, 32'h22, 1, 1, 1};
    vecs[6]  = '{0, 0,  0,            0, 0,  0,     1, 5,  0, 32'h11,       32'h22, 1, 1, 1};
    vecs[7]  = '{0, 0,  0,            1, 0,  32'h99, 0, 5, 0, 32'h11,       32'h22, 1, 1, 0};
    vecs[8]  = '{0, 0,  0,            0, 0,  0,     0, 5,  0, 32'h11,       32'h22, 1, 1, 0};
    vecs[9]  = '{0, 0,  0,            1, 12, 32'h66, 0, 5, 0, 32'h11,       32'h22, 1, 1, 0};
    vecs[10] = '{0, 0,  0,            0, 0,  0,     0, 5,  0, 32'h11,       32'h22, 1, 1, 1};
    vecs[11] = '{1, 10, 32'h55,       1, 7,  32'hAA, 1, 12, 1, 32'h11,      32'h66, 1, 1, 1};
    vecs[12] = '{1, 7,  32'hBB,       0, 0,  0,     0, 12, 1, 32'h11,       32'h66, 1, 0, 1};
    vecs[13] = '{0, 0,  0,            0, 0,  0,     1, 10, 0, 32'h55,       32'h66, 0, 1, 1};
    vecs[14] = '{0, 0,  0,            0, 0,  0,     1, 7,  1, 32'h55,       32'hAA, 1, 1, 1};
    vecs[15] = '{0, 0,  0,            0, 0,  0,     1, 7,  0, 32'hBB,       32'hAA, 1, 1, 1};
    vecs[16] = '{0, 0,  0,            0, 0,  0,     0, 7,  0, 32'hBB,       32'hAA, 1, 1, 0};

    drive(0, 0, 0, 0, 0, 0);
    #1 check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      check($sformatf("v%0d_rf_we", i),     64'(bus.rf_we),     64'(vecs[i].we));
      check($sformatf("v%0d_rf_waddr", i),  64'(bus.rf_waddr),  64'(vecs[i].wa));
      check($sformatf("v%0d_wd_sel", i),    64'(bus.wd_sel),    64'(vecs[i].sel));
      check($sformatf("v%0d_wd_data0", i),  64'(bus.wd_data0),  64'(vecs[i].d0));
      check($sformatf("v%0d_wd_data1", i),  64'(bus.wd_data1),  64'(vecs[i].d1));
      check($sformatf("v%0d_alu_ready", i), 64'(bus.alu_ready), 64'(vecs[i].ar));
      check($sformatf("v%0d_ld_ready", i),  64'(bus.ld_ready),  64'(vecs[i].lr));
      check($sformatf("v%0d_wb_busy", i),   64'(bus.wb_busy),   64'(vecs[i].busy));
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
      @(negedge clk);
    end

    // Tie straight after reset: the ALU wins, the load follows.
    rst_n = 1'b0;
    #1 check_reset_values("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 5, 32'h11, 1, 6, 32'h22);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    check("tie_grant_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("tie_grant_ld_ready",  64'(bus.ld_ready),  64'd0);
    check("tie_c0_rf_we",        64'(bus.rf_we),     64'd0);
    @(negedge clk);
    check("tie_c1_rf_we",    64'(bus.rf_we),    64'd1);
    check("tie_c1_wd_sel",   64'(bus.wd_sel),   64'd0);
    check("tie_c1_rf_waddr", 64'(bus.rf_waddr), 64'd5);
    check("tie_c1_wd_data0", 64'(bus.wd_data0), 64'h11);
    @(negedge clk);
    check("tie_c2_rf_we",    64'(bus.rf_we),    64'd1);
    check("tie_c2_wd_sel",   64'(bus.wd_sel),   64'd1);
    check("tie_c2_rf_waddr", 64'(bus.rf_waddr), 64'd6);
    check("tie_c2_wd_data1", 64'(bus.wd_data1), 64'h22);
    @(negedge clk);
    check("tie_c3_rf_we",   64'(bus.rf_we),   64'd0);
    check("tie_c3_wb_busy", 64'(bus.wb_busy), 64'd0);

    // Both sources valid for 8 edges: one write per cycle, alternating, ALU first.
    prev_ar = 1'b1;
    prev_lr = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      exp_we  = (c >= 2) && (c <= 10);
      exp_sel = (c % 2 == 1);
      check($sformatf("cont%0d_rf_we", c), 64'(bus.rf_we), 64'(exp_we));
      if (exp_we) begin
        check($sformatf("cont%0d_wd_sel", c),   64'(bus.wd_sel),   64'(exp_sel));
        check($sformatf("cont%0d_rf_waddr", c), 64'(bus.rf_waddr), exp_sel ? 64'd2 : 64'd1);
      end
      if (c >= 1 && c <= 9) begin
        check($sformatf("cont%0d_alu_not_starved", c), 64'(bus.alu_ready | prev_ar), 64'd1);
        check($sformatf("cont%0d_ld_not_starved", c),  64'(bus.ld_ready | prev_lr),  64'd1);
      end
      prev_ar = bus.alu_ready;
      prev_lr = bus.ld_ready;
      if (c < 8) drive(1, 1, 32'h100 + c, 1, 2, 32'h200 + c);
      else       drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
    end

    // Reset while both slots are full and a write is issuing.
    drive(1, 3, 32'h333, 1, 4, 32'h444);
    @(negedge clk);
    @(negedge clk);
    check("midrst_pre_rf_we",   64'(bus.rf_we),   64'd1);
    check("midrst_pre_busy",    64'(bus.wb_busy), 64'd1);
    check("midrst_pre_alu_rdy", 64'(bus.alu_ready & bus.ld_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_rf_we", c),   64'(bus.rf_we),   64'd0);
      check($sformatf("post_rst%0d_wb_busy", c), 64'(bus.wb_busy), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
